// File: rtl/ramio.sv
// ramio: byte/half/word load-store adapter in front of the Cache (br_clk_out domain).
// Takes one sized access per request and does three things:
//   - converts the byte address to a word-aligned Cache address,
//   - builds the 4-bit byte-lane write mask and lane-shifted store data,
//   - sign- or zero-extends the selected lanes of a read word.
// Optional feature: define RAMIO_ALIGN_CHECK_EN to turn on misalignment detection.
//   - Misaligned half/word accesses then set a sticky error and are dropped.
//   - Without the macro, low address bits are ignored and the access goes to the
//     aligned unit that contains the address.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                request strobe (sampled only while idle)
//   address               byte address of the access
//   read_type             000 none, 001 byte, 010 half, 011 word, 101 sbyte, 110 shalf
//   write_type            00 none, 01 byte, 10 half, 11 word (wins over read_type)
//   data_in               right-justified store data
//   data_out              extended load result, held until the next load completes
//   data_out_ready        one-cycle pulse when data_out is updated
//   busy                  request in flight
//   error                 sticky misalignment flag (0 unless RAMIO_ALIGN_CHECK_EN)
//   cache_address         {address[31:2],2'b00}
//   cache_data_in         lane-shifted store data
//   cache_write_enable    byte-lane mask, nonzero for exactly one cycle per store
//   cache_data_out        Cache read word
//   cache_data_out_ready  Cache read data valid
//   cache_busy            Cache servicing a write or miss
module ramio #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [2:0]                  read_type,
  input  logic [1:0]                  write_type,
  input  logic [DATA_BITWIDTH-1:0]    data_in,
  output logic [DATA_BITWIDTH-1:0]    data_out,
  output logic                        data_out_ready,
  output logic                        busy,
  output logic                        error,
  output logic [ADDRESS_BITWIDTH-1:0] cache_address,
  output logic [DATA_BITWIDTH-1:0]    cache_data_in,
  output logic [3:0]                  cache_write_enable,
  input  logic [DATA_BITWIDTH-1:0]    cache_data_out,
  input  logic                        cache_data_out_ready,
  input  logic                        cache_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRITE_WAIT,
    S_READ,
    S_READ_WAIT
  } state_t;

  state_t                        r_state;
  logic [DATA_BITWIDTH-1:0]      r_data_out;
  logic                          r_data_out_ready;
  logic                          r_busy;
  logic [ADDRESS_BITWIDTH-1:0]   r_cache_address;
  logic [DATA_BITWIDTH-1:0]      r_cache_data_in;
  logic [3:0]                    r_cache_write_enable;
  logic [1:0]                    r_roff;
  logic [1:0]                    r_rsize;
  logic                          r_rsign;

  logic [3:0]                    w_wmask;
  logic [DATA_BITWIDTH-1:0]      w_wdata;
  logic [1:0]                    w_roff;
  logic [DATA_BITWIDTH-1:0]      w_rshift;
  logic [DATA_BITWIDTH-1:0]      w_rdata;
  logic                          w_wmis;
  logic                          w_rmis;

  // Store lanes: half uses address[1] only, word ignores both low bits.
  always_comb begin
    w_wmask = '0;
    w_wdata = '0;
    case (write_type)
      2'b01: begin
        w_wmask = 4'b0001 << address[1:0];
        w_wdata = {24'b0, data_in[7:0]} << {address[1:0], 3'b000};
      end
      2'b10: begin
        w_wmask = address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {16'b0, data_in[15:0]} << {address[1], 4'b0000};
      end
      2'b11: begin
        w_wmask = 4'b1111;
        w_wdata = data_in;
      end
      default: ;
    endcase
  end

  // Byte offset of the lowest lane a load reads, normalised to the access size.
  always_comb begin
    w_roff = '0;
    case (read_type[1:0])
      2'b01:   w_roff = address[1:0];
      2'b10:   w_roff = {address[1], 1'b0};
      default: w_roff = '0;
    endcase
  end

  assign w_rshift = cache_data_out >> {r_roff, 3'b000};

  // Encodings with size 00 (e.g. 100) fall through to a plain word load.
  always_comb begin
    w_rdata = w_rshift;
    case (r_rsize)
      2'b01:   w_rdata = {{24{r_rsign & w_rshift[7]}},  w_rshift[7:0]};
      2'b10:   w_rdata = {{16{r_rsign & w_rshift[15]}}, w_rshift[15:0]};
      default: w_rdata = w_rshift;
    endcase
  end

`ifdef RAMIO_ALIGN_CHECK_EN
  logic r_error;

  assign w_wmis = (write_type == 2'b10 && address[0]) ||
                  (write_type == 2'b11 && address[1:0] != 2'b00);
  assign w_rmis = (read_type[1:0] == 2'b10 && address[0]) ||
                  (read_type[1:0] == 2'b11 && address[1:0] != 2'b00);

  // Only the access that would actually be started is checked (write wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (r_state == S_IDLE && enable &&
                 ((write_type != 2'b00 && w_wmis) ||
                  (write_type == 2'b00 && read_type != 3'b000 && w_rmis))) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign w_wmis = 1'b0;
  assign w_rmis = 1'b0;
  assign error  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= S_IDLE;
      r_data_out           <= '0;
      r_data_out_ready     <= 1'b0;
      r_busy               <= 1'b0;
      r_cache_address      <= '0;
      r_cache_data_in      <= '0;
      r_cache_write_enable <= '0;
      r_roff               <= '0;
      r_rsize              <= '0;
      r_rsign              <= 1'b0;
    end else begin
      r_data_out_ready     <= 1'b0;
      r_cache_write_enable <= '0;
      case (r_state)
        S_IDLE: begin
          if (enable && write_type != 2'b00) begin
            if (!w_wmis) begin
              r_state              <= S_WRITE;
              r_busy               <= 1'b1;
              r_cache_address      <= {address[ADDRESS_BITWIDTH-1:2], 2'b00};
              r_cache_data_in      <= w_wdata;
              r_cache_write_enable <= w_wmask;
            end
          end else if (enable && read_type != 3'b000) begin
            if (!w_rmis) begin
              r_state         <= S_READ;
              r_busy          <= 1'b1;
              r_cache_address <= {address[ADDRESS_BITWIDTH-1:2], 2'b00};
              r_roff          <= w_roff;
              r_rsize         <= read_type[1:0];
              r_rsign         <= read_type[2];
            end
          end
        end
        // Mask was registered on entry; it drops back to 0 on leaving.
        S_WRITE: r_state <= S_WRITE_WAIT;
        // The Cache raised busy in response to the write during this cycle, so
        // checking it here already gives the Cache its one cycle to react.
        S_WRITE_WAIT: begin
          if (!cache_busy) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        // Ready seen during READ may belong to a previous access; ignore it.
        S_READ: r_state <= S_READ_WAIT;
        S_READ_WAIT: begin
          if (cache_data_out_ready) begin
            r_data_out       <= w_rdata;
            r_data_out_ready <= 1'b1;
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out           = r_data_out;
  assign data_out_ready     = r_data_out_ready;
  assign busy               = r_busy;
  assign cache_address      = r_cache_address;
  assign cache_data_in      = r_cache_data_in;
  assign cache_write_enable = r_cache_write_enable;

endmodule

// File: tb/tb_ramio.sv
module tb_ramio;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [2:0]  read_type = '0;
  logic [1:0]  write_type = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        error;
  logic [31:0] cache_address;
  logic [31:0] cache_data_in;
  logic [3:0]  cache_write_enable;
  logic [31:0] cache_data_out = '0;
  logic        cache_data_out_ready;
  logic        cache_busy = 1'b0;

  ramio #(.ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .read_type(read_type), .write_type(write_type), .data_in(data_in),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy),
    .error(error), .cache_address(cache_address), .cache_data_in(cache_data_in),
    .cache_write_enable(cache_write_enable), .cache_data_out(cache_data_out),
    .cache_data_out_ready(cache_data_out_ready), .cache_busy(cache_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Cache stand-in: word memory, write busy, controllable ready
  bit [31:0] cmem [bit [31:0]];
  bit [31:0] cm_w;
  bit [31:0] cm_idx;
  int        cfg_busy = 0;
  int        cb_cnt = 0;
  logic      c_ready = 1'b1;

  assign cache_data_out_ready = c_ready;

  function automatic bit [31:0] cm_rd(input bit [31:0] idx);
    return cmem.exists(idx) ? cmem[idx] : 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_cnt     <= 0;
      cache_busy <= 1'b0;
    end else if (cache_write_enable != 4'b0000) begin
      cm_idx = {2'b00, cache_address[31:2]};
      cm_w   = cm_rd(cm_idx);
      for (int k = 0; k < 4; k++)
        if (cache_write_enable[k]) cm_w[8*k +: 8] = cache_data_in[8*k +: 8];
      cmem[cm_idx] = cm_w;
      cb_cnt     <= cfg_busy;
      cache_busy <= (cfg_busy != 0);
    end else if (cb_cnt > 0) begin
      cb_cnt     <= cb_cnt - 1;
      cache_busy <= (cb_cnt > 1);
    end
  end

  always @(posedge clk) cache_data_out <= cm_rd({2'b00, cache_address[31:2]});

  // ---------------- Reference model: byte-addressed memory, little-endian
  bit [7:0]    refmem [bit [31:0]];
  logic [3:0]  exp_mask;
  logic [31:0] exp_wdata;
  logic [31:0] exp_caddr;
  logic [31:0] exp_load;

  function automatic int unsigned sz(input logic [1:0] t);
    return (t == 2'b01) ? 1 : (t == 2'b10) ? 2 : 4;
  endfunction

  function automatic bit [7:0] rbyte(input bit [31:0] a);
    return refmem.exists(a) ? refmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] wt,
                                      input logic [31:0] d);
    int unsigned n;
    logic [31:0] base;
    logic [31:0] ba;
    n         = sz(wt);
    base      = a & ~(n - 1);
    exp_mask  = '0;
    exp_wdata = '0;
    exp_caddr = {a[31:2], 2'b00};
    for (int unsigned k = 0; k < n; k++) begin
      ba = base + k;
      exp_mask[ba[1:0]]           = 1'b1;
      exp_wdata[8*ba[1:0] +: 8]   = d[8*k +: 8];
      refmem[ba]                  = d[8*k +: 8];
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] rt);
    int unsigned n;
    logic [31:0] base;
    logic [31:0] v;
    n    = sz(rt[1:0]);
    base = a & ~(n - 1);
    v    = '0;
    for (int unsigned k = 0; k < n; k++) v[8*k +: 8] = rbyte(base + k);
    if (rt[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  // ---------------- Compare process
  int          we_count = 0;
  int          rdy_count = 0;
  logic [3:0]  last_we = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_caddr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cache_write_enable != 4'b0000) begin
        we_count++;
        last_we    = cache_write_enable;
        last_wdata = cache_data_in;
        last_caddr = cache_address;
        check("we_mask", {28'b0, cache_write_enable}, {28'b0, exp_mask});
        check("we_addr", cache_address, exp_caddr);
        check("we_data", cache_data_in & lanes(cache_write_enable),
              exp_wdata & lanes(exp_mask));
      end
      if (data_out_ready) begin
        rdy_count++;
        check("load_data", data_out, exp_load);
      end
    end
  end

  // ---------------- Stimulus
  task automatic do_store(input logic [31:0] a, input logic [1:0] wt, input logic [31:0] d,
                          input int bc, input logic [2:0] rt);
    int n;
    int wb;
    int rb;
    model_store(a, wt, d);
    cfg_busy = bc;
    wb = we_count;
    rb = rdy_count;
    @(negedge clk);
    enable = 1'b1; address = a; write_type = wt; read_type = rt; data_in = d;
    @(negedge clk);
    enable = 1'b0; write_type = '0; read_type = '0;
    check("store_busy_set", {31'b0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("store_latency", n, 2 + bc);
    @(negedge clk);
    #1;
    check("store_we_pulses", we_count - wb, 32'd1);
    check("store_no_ready", rdy_count - rb, 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] rt, input int miss);
    int n;
    int wb;
    int rb;
    exp_load = model_load(a, rt);
    wb = we_count;
    rb = rdy_count;
    if (miss > 0) c_ready = 1'b0;
    @(negedge clk);
    enable = 1'b1; address = a; read_type = rt; write_type = '0;
    @(negedge clk);
    enable = 1'b0; read_type = '0;
    check("load_busy_set", {31'b0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (miss > 0 && n == miss) c_ready = 1'b1;
      if (miss > 0 && n < miss && (n % 2) == 1) begin
        enable = 1'b1; write_type = 2'b11; address = 32'h40; data_in = 32'h12345678;
      end else begin
        enable = 1'b0; write_type = '0;
      end
      @(negedge clk);
    end
    enable = 1'b0; write_type = '0; c_ready = 1'b1;
    check("load_latency", n, (miss > 0) ? miss : 2);
    @(negedge clk);
    #1;
    check("load_ready_pulses", rdy_count - rb, 32'd1);
    check("load_ready_low", {31'b0, data_out_ready}, 32'd0);
    check("load_no_write", we_count - wb, 32'd0);
    check("load_hold", data_out, exp_load);
  endtask

  initial begin
    int wb;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_we", {28'b0, cache_write_enable}, 32'd0);
    check("rst_ready", {31'b0, data_out_ready}, 32'd0);
    check("rst_dout", data_out, 32'd0);
    check("rst_caddr", cache_address, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: word store, Cache busy for 3 cycles afterwards
    do_store(32'h10, 2'b11, 32'hDEADBEEF, 3, 3'b000);
    check("t1_mask", {28'b0, last_we}, 32'h0000000F);
    check("t1_caddr", last_caddr, 32'h00000010);

    // 2: byte store to top lane, signed and unsigned reloads
    do_store(32'h13, 2'b01, 32'h000000A5, 0, 3'b000);
    check("t2_mask", {28'b0, last_we}, 32'h00000008);
    check("t2_lane", {24'b0, last_wdata[31:24]}, 32'h000000A5);
    do_load(32'h13, 3'b101, 0);
    check("t2_sbyte", data_out, 32'hFFFFFFA5);
    do_load(32'h13, 3'b001, 0);
    check("t2_ubyte", data_out, 32'h000000A5);

    // 3: half store to upper half, signed and unsigned reloads
    do_store(32'h22, 2'b10, 32'h00008001, 1, 3'b000);
    check("t3_mask", {28'b0, last_we}, 32'h0000000C);
    do_load(32'h22, 3'b110, 0);
    check("t3_shalf", data_out, 32'hFFFF8001);
    do_load(32'h22, 3'b010, 0);
    check("t3_uhalf", data_out, 32'h00008001);

    // 4: word load with a 20-cycle miss and ignored enable pulses
    do_load(32'h10, 3'b011, 20);
    check("t4_word", data_out, 32'hA5ADBEEF);

    // write wins over read; byte lane 1
    do_store(32'h31, 2'b01, 32'h0000005A, 0, 3'b011);
    check("ww_mask", {28'b0, last_we}, 32'h00000002);
    do_load(32'h31, 3'b001, 0);
    check("ww_byte", data_out, 32'h0000005A);

    // address wrap: top byte of the address space
    do_store(32'hFFFFFFFF, 2'b01, 32'h0000009C, 0, 3'b000);
    check("wrap_caddr", last_caddr, 32'hFFFFFFFC);
    check("wrap_mask", {28'b0, last_we}, 32'h00000008);
    do_load(32'hFFFFFFFF, 3'b101, 0);
    check("wrap_sbyte", data_out, 32'hFFFFFF9C);

    // no-op request
    wb = we_count;
    @(negedge clk);
    enable = 1'b1; address = 32'h50; write_type = '0; read_type = '0;
    @(negedge clk);
    enable = 1'b0;
    check("noop_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("noop_busy2", {31'b0, busy}, 32'd0);
    check("noop_we", we_count - wb, 32'd0);

    // 5: misaligned word store
`ifdef RAMIO_ALIGN_CHECK_EN
    wb = we_count;
    @(negedge clk);
    enable = 1'b1; address = 32'h06; write_type = 2'b11; data_in = 32'hCAFEF00D;
    @(negedge clk);
    enable = 1'b0; write_type = '0;
    for (int i = 0; i < 3; i++) begin
      check("t5_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
    end
    check("t5_error", {31'b0, error}, 32'd1);
    check("t5_no_write", we_count - wb, 32'd0);
`else
    do_store(32'h06, 2'b11, 32'hCAFEF00D, 0, 3'b000);
    check("t5_caddr", last_caddr, 32'h00000004);
    check("t5_mask", {28'b0, last_we}, 32'h0000000F);
    check("t5_error", {31'b0, error}, 32'd0);
    do_load(32'h04, 3'b011, 0);
    check("t5_word", data_out, 32'hCAFEF00D);
`endif

    // 6: reset during WRITE_WAIT; the write already reached the Cache
    model_store(32'h10, 2'b11, 32'hDEADBEEF);
    cfg_busy = 5;
    @(negedge clk);
    enable = 1'b1; address = 32'h10; write_type = 2'b11; read_type = '0; data_in = 32'hDEADBEEF;
    @(negedge clk);
    enable = 1'b0; write_type = '0;
    check("t6_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_we", {28'b0, cache_write_enable}, 32'd0);
    check("t6_rst_ready", {31'b0, data_out_ready}, 32'd0);
    check("t6_rst_dout", data_out, 32'd0);
    check("t6_rst_caddr", cache_address, 32'd0);
    check("t6_rst_cdin", cache_data_in, 32'd0);
    check("t6_rst_error", {31'b0, error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(32'h10, 3'b011, 0);
    check("t6_word", data_out, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
